// File: rtl/mem_to_axi_mst.sv
// Single-outstanding bridge from a req/gnt memory port to a single-beat AXI4 master.
// The mem side gets no further grant until the response pulse of the current access.
module mem_to_axi_mst #(
   parameter int ADDR_WIDTH   = 32,
   parameter int MEM_DW       = 32,
   parameter int AXI_DW       = 64,
   parameter int AXI_ID_WIDTH = 4,
   parameter int AXI_ID       = 0
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    req_i,
   output logic                    gnt_o,
   input  logic                    we_i,
   input  logic [MEM_DW/8-1:0]     be_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [MEM_DW-1:0]       wdata_i,
   output logic                    rsp_valid_o,
   output logic [MEM_DW-1:0]       rsp_rdata_o,
   output logic                    rsp_err_o,
   output logic                    aw_valid_o,
   input  logic                    aw_ready_i,
   output logic [ADDR_WIDTH-1:0]   aw_addr_o,
   output logic [AXI_ID_WIDTH-1:0] aw_id_o,
   output logic [7:0]              aw_len_o,
   output logic [2:0]              aw_size_o,
   output logic [1:0]              aw_burst_o,
   output logic                    w_valid_o,
   input  logic                    w_ready_i,
   output logic [AXI_DW-1:0]       w_data_o,
   output logic [AXI_DW/8-1:0]     w_strb_o,
   output logic                    w_last_o,
   input  logic                    b_valid_i,
   output logic                    b_ready_o,
   input  logic [1:0]              b_resp_i,
   output logic                    ar_valid_o,
   input  logic                    ar_ready_i,
   output logic [ADDR_WIDTH-1:0]   ar_addr_o,
   output logic [AXI_ID_WIDTH-1:0] ar_id_o,
   output logic [7:0]              ar_len_o,
   output logic [2:0]              ar_size_o,
   output logic [1:0]              ar_burst_o,
   input  logic                    r_valid_i,
   output logic                    r_ready_o,
   input  logic [AXI_DW-1:0]       r_data_i,
   input  logic [1:0]              r_resp_i,
   input  logic                    r_last_i,
   output logic [2:0]              state_o
);

   localparam int MEM_BW    = MEM_DW / 8;
   localparam int AXI_BW    = AXI_DW / 8;
   localparam int NUM_LANES = AXI_DW / MEM_DW;
   localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int MEM_OFF   = $clog2(MEM_BW);

   typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, WR_RSP, RD_RSP, RESP} state_t;

   state_t                  state, state_next;
   logic [MEM_BW-1:0]       be_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [MEM_DW-1:0]       wdata_q;
   logic [MEM_DW-1:0]       rdata_q;
   logic                    err_q;
   logic                    aw_done, w_done;
   logic [LANE_W-1:0]       lane;
   logic [AXI_BW-1:0]       strb_base;
   logic                    unused_r_last;

   assign unused_r_last = r_last_i;

   if (NUM_LANES > 1) begin : g_lane
      assign lane = addr_q[MEM_OFF +: LANE_W];
   end else begin : g_no_lane
      assign lane = '0;
   end

   // Every channel transfers on a cycle where valid and ready are both high;
   // valids never wait on readies and, once raised, stay up with stable payload until that cycle.
   always_comb begin
      state_next  = state;
      gnt_o       = 1'b0;
      aw_valid_o  = 1'b0;
      w_valid_o   = 1'b0;
      b_ready_o   = 1'b0;
      ar_valid_o  = 1'b0;
      r_ready_o   = 1'b0;
      rsp_valid_o = 1'b0;
      case (state)
         IDLE: begin
            gnt_o = req_i;
            if (req_i) state_next = we_i ? WR_REQ : RD_REQ;
         end
         WR_REQ: begin
            aw_valid_o = !aw_done;
            w_valid_o  = !w_done;
            if ((aw_done || aw_ready_i) && (w_done || w_ready_i)) state_next = WR_RSP;
         end
         WR_RSP: begin
            b_ready_o = 1'b1;
            if (b_valid_i) state_next = RESP;
         end
         RD_REQ: begin
            ar_valid_o = 1'b1;
            if (ar_ready_i) state_next = RD_RSP;
         end
         RD_RSP: begin
            r_ready_o = 1'b1;
            if (r_valid_i) state_next = RESP;
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            state_next  = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= IDLE;
         be_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         state <= state_next;
         if (gnt_o) begin
            be_q    <= be_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (aw_valid_o && aw_ready_i) aw_done <= 1'b1;
         if (w_valid_o && w_ready_i) w_done <= 1'b1;
         if (b_ready_o && b_valid_i) begin
            err_q   <= (b_resp_i != 2'b00);
            rdata_q <= '0;
         end
         if (r_ready_o && r_valid_i) begin
            err_q   <= (r_resp_i != 2'b00);
            rdata_q <= r_data_i[int'(lane)*MEM_DW +: MEM_DW];
         end
      end
   end

   // The mem word is copied to every lane; only the strobes pick the addressed one.
   always_comb begin
      strb_base             = '0;
      strb_base[MEM_BW-1:0] = be_q;
   end

   assign w_strb_o    = strb_base << (int'(lane) * MEM_BW);
   assign w_data_o    = {NUM_LANES{wdata_q}};
   assign w_last_o    = 1'b1;
   assign aw_addr_o   = addr_q;
   assign ar_addr_o   = addr_q;
   assign aw_id_o     = AXI_ID_WIDTH'(AXI_ID);
   assign ar_id_o     = AXI_ID_WIDTH'(AXI_ID);
   assign aw_len_o    = 8'd0;
   assign ar_len_o    = 8'd0;
   assign aw_size_o   = 3'(MEM_OFF);
   assign ar_size_o   = 3'(MEM_OFF);
   assign aw_burst_o  = 2'b01;
   assign ar_burst_o  = 2'b01;
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;
   assign state_o     = state;

endmodule

// File: tb/tb_mem_to_axi_mst.sv
// Bench for mem_to_axi_mst: a 64-bit-AXI instance and a 32-bit-AXI instance run in lockstep
// on shared stimulus; a scripted AXI slave and a spec-level model supply the expectations.
module tb_mem_to_axi_mst;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- shared stimulus ----------------
   logic        req = 1'b0, we = 1'b0;
   logic [3:0]  be = '0;
   logic [31:0] addr = '0, wdata = '0;
   logic        aw_ready = 1'b0, w_ready = 1'b0, b_valid = 1'b0, ar_ready = 1'b0, r_valid = 1'b0, r_last = 1'b0;
   logic [1:0]  b_resp = '0, r_resp = '0;
   logic [63:0] r_data = '0;

   // ---------------- 64-bit AXI instance outputs ----------------
   logic        gnt, rsp_valid, rsp_err, aw_valid, w_valid, w_last, b_ready, ar_valid, r_ready;
   logic [31:0] rsp_rdata, aw_addr, ar_addr;
   logic [3:0]  aw_id, ar_id;
   logic [7:0]  aw_len, ar_len, w_strb;
   logic [2:0]  aw_size, ar_size, unused_state64;
   logic [1:0]  aw_burst, ar_burst;
   logic [63:0] w_data;

   // ---------------- 32-bit AXI instance outputs ----------------
   logic        gnt32, rsp_valid32, rsp_err32, aw_valid32, w_valid32, w_last32, b_ready32, ar_valid32, r_ready32;
   logic [31:0] rsp_rdata32, aw_addr32, ar_addr32, w_data32;
   logic [3:0]  aw_id32, ar_id32, w_strb32;
   logic [7:0]  aw_len32, ar_len32;
   logic [2:0]  aw_size32, ar_size32, unused_state32;
   logic [1:0]  aw_burst32, ar_burst32;

   mem_to_axi_mst dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .we_i(we), .be_i(be),
      .addr_i(addr), .wdata_i(wdata), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
      .rsp_err_o(rsp_err), .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr),
      .aw_id_o(aw_id), .aw_len_o(aw_len), .aw_size_o(aw_size), .aw_burst_o(aw_burst),
      .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data), .w_strb_o(w_strb),
      .w_last_o(w_last), .b_valid_i(b_valid), .b_ready_o(b_ready), .b_resp_i(b_resp),
      .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr), .ar_id_o(ar_id),
      .ar_len_o(ar_len), .ar_size_o(ar_size), .ar_burst_o(ar_burst), .r_valid_i(r_valid),
      .r_ready_o(r_ready), .r_data_i(r_data), .r_resp_i(r_resp), .r_last_i(r_last),
      .state_o(unused_state64)
   );

   mem_to_axi_mst #(.AXI_DW(32)) dut32 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt32), .we_i(we), .be_i(be),
      .addr_i(addr), .wdata_i(wdata), .rsp_valid_o(rsp_valid32), .rsp_rdata_o(rsp_rdata32),
      .rsp_err_o(rsp_err32), .aw_valid_o(aw_valid32), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr32),
      .aw_id_o(aw_id32), .aw_len_o(aw_len32), .aw_size_o(aw_size32), .aw_burst_o(aw_burst32),
      .w_valid_o(w_valid32), .w_ready_i(w_ready), .w_data_o(w_data32), .w_strb_o(w_strb32),
      .w_last_o(w_last32), .b_valid_i(b_valid), .b_ready_o(b_ready32), .b_resp_i(b_resp),
      .ar_valid_o(ar_valid32), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr32), .ar_id_o(ar_id32),
      .ar_len_o(ar_len32), .ar_size_o(ar_size32), .ar_burst_o(ar_burst32), .r_valid_i(r_valid),
      .r_ready_o(r_ready32), .r_data_i(r_data[31:0]), .r_resp_i(r_resp), .r_last_i(r_last),
      .state_o(unused_state32)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int failures = 0;
   logic [32:0] exp_q[$];          // {err, rdata} per accepted request
   logic [31:0] last_rdata = '0;
   logic        last_err = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_bound(input string name);
      checks++;
      failures++;
      $display("FAIL %s: wait bound expired, got no handshake, expected one at %0t", name, $time);
   endtask

   // ---------------- vectors and reference model ----------------
   typedef struct {
      logic        wr;
      logic [3:0]  be;
      logic [31:0] addr, wdata;
      logic [63:0] rdata;
      logic [1:0]  resp;
      int          lat_aw, lat_w, lat_b, lat_ar, lat_r;
      logic        hold;
      logic [7:0]  exp_strb;
      logic [63:0] exp_wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[7];

   function automatic vec_t make_random();
      vec_t v;
      int   lane;
      v.wr     = 1'($urandom_range(0, 1));
      v.be     = 4'($urandom_range(1, 15));
      v.addr   = $urandom;
      v.wdata  = $urandom;
      v.rdata  = {$urandom, $urandom};
      v.resp   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      v.lat_aw = $urandom_range(0, 3);
      v.lat_w  = $urandom_range(0, 3);
      v.lat_b  = $urandom_range(0, 3);
      v.lat_ar = $urandom_range(0, 3);
      v.lat_r  = $urandom_range(0, 3);
      v.hold   = 1'($urandom_range(0, 1));
      // The addressed 32-bit word inside the 64-bit beat
      lane        = int'(v.addr % 8) / 4;
      v.exp_strb  = 8'(v.be) * ((lane == 1) ? 8'd16 : 8'd1);
      v.exp_wdata = {v.wdata, v.wdata};
      v.exp_rdata = v.wr ? 32'd0 : 32'(v.rdata >> (32 * lane));
      v.exp_err   = (v.resp != 2'b00);
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic scramble();
      we    = 1'($urandom_range(0, 1));
      be    = 4'($urandom);
      addr  = $urandom;
      wdata = $urandom;
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_ctrl"}, {gnt, rsp_valid, rsp_err, aw_valid, w_valid, b_ready, ar_valid, r_ready,
                              gnt32, rsp_valid32, rsp_err32, aw_valid32, w_valid32, b_ready32, ar_valid32, r_ready32}, 0);
      check({name, "_rdata"}, {rsp_rdata, rsp_rdata32}, 0);
   endtask

   task automatic run_txn(input vec_t v, input logic abort);
      int   cyc;
      logic done_a, done_b;
      logic [32:0] exp;
      // T0: request presented, grant expected combinationally
      @(negedge clk);
      req = 1'b1; we = v.wr; be = v.be; addr = v.addr; wdata = v.wdata;
      aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0; b_valid = 1'b0; r_valid = 1'b0;
      #1;
      check("gnt", gnt, 1);
      check("gnt32", gnt32, 1);
      check("rsp_one_cycle", rsp_valid, 0);
      check("rsp_rdata_hold", rsp_rdata, last_rdata);
      check("rsp_err_hold", rsp_err, last_err);
      check("axi_const", {aw_id, aw_len, aw_size, aw_burst, ar_id, ar_len, ar_size, ar_burst, w_last},
            {4'd0, 8'd0, 3'd2, 2'd1, 4'd0, 8'd0, 3'd2, 2'd1, 1'b1});
      check("axi_const32", {aw_id32, aw_len32, aw_size32, aw_burst32, ar_id32, ar_len32, ar_size32, ar_burst32, w_last32},
            {4'd0, 8'd0, 3'd2, 2'd1, 4'd0, 8'd0, 3'd2, 2'd1, 1'b1});
      if (!abort) exp_q.push_back({v.exp_err, v.exp_rdata});

      // Address/data phase
      cyc = 0; done_a = 1'b0; done_b = !v.wr;
      while (!(done_a && done_b)) begin
         @(negedge clk);
         req = v.hold; scramble();
         if (v.wr) begin
            aw_ready = (cyc >= v.lat_aw);
            w_ready  = (cyc >= v.lat_w);
         end else begin
            ar_ready = (cyc >= v.lat_ar);
         end
         #1;
         check("gnt_busy", gnt, 0);
         check("b_ready_early", b_ready, 0);
         check("r_ready_early", r_ready, 0);
         check("rsp_busy", rsp_valid, 0);
         if (v.wr) begin
            check("aw_valid", aw_valid, !done_a);
            check("w_valid", w_valid, !done_b);
            check("aw_valid32", aw_valid32, !done_a);
            check("w_valid32", w_valid32, !done_b);
            check("ar_valid_on_wr", ar_valid, 0);
            if (!done_a) begin
               check("aw_addr", aw_addr, v.addr);
               check("aw_addr32", aw_addr32, v.addr);
            end
            if (!done_b) begin
               check("w_data", w_data, v.exp_wdata);
               check("w_strb", w_strb, v.exp_strb);
               check("w_data32", w_data32, v.wdata);
               check("w_strb32", w_strb32, v.be);
            end
            if (aw_ready) done_a = 1'b1;
            if (w_ready) done_b = 1'b1;
         end else begin
            check("ar_valid", ar_valid, 1);
            check("ar_valid32", ar_valid32, 1);
            check("aw_valid_on_rd", {aw_valid, w_valid}, 0);
            check("ar_addr", ar_addr, v.addr);
            check("ar_addr32", ar_addr32, v.addr);
            if (ar_ready) done_a = 1'b1;
         end
         cyc++;
         if (cyc > 40) begin
            fail_bound("req_phase");
            break;
         end
      end

      // Response phase
      cyc = 0; done_a = 1'b0;
      while (!done_a) begin
         @(negedge clk);
         req = v.hold; scramble();
         aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
         if (v.wr) begin
            b_valid = (cyc >= v.lat_b);
            b_resp  = b_valid ? v.resp : 2'($urandom);
         end else begin
            r_valid = (cyc >= v.lat_r);
            r_data  = r_valid ? v.rdata : {$urandom, $urandom};
            r_resp  = r_valid ? v.resp : 2'($urandom);
            r_last  = 1'b1;
         end
         #1;
         check("gnt_busy", gnt, 0);
         check("rsp_busy", rsp_valid, 0);
         check("req_valids_low", {aw_valid, w_valid, ar_valid}, 0);
         if (v.wr) begin
            check("b_ready", b_ready, 1);
            check("b_ready32", b_ready32, 1);
            check("r_ready_on_wr", r_ready, 0);
         end else begin
            check("r_ready", r_ready, 1);
            check("r_ready32", r_ready32, 1);
            check("b_ready_on_rd", b_ready, 0);
         end
         if (abort && cyc == 1) begin
            rst_n = 1'b0;
            #1;
            check_reset_outputs("mid_reset");
            #2;
            rst_n = 1'b1;
            b_valid = 1'b0; r_valid = 1'b0; req = 1'b0;
            last_rdata = '0; last_err = 1'b0;
            repeat (2) begin
               @(negedge clk);
               #1;
               check("no_rsp_after_abort", {rsp_valid, rsp_valid32}, 0);
               check("idle_after_abort", {aw_valid, w_valid, b_ready, ar_valid, r_ready}, 0);
            end
            return;
         end
         if (v.wr ? b_valid : r_valid) done_a = 1'b1;
         cyc++;
         if (cyc > 40) begin
            fail_bound("rsp_phase");
            break;
         end
      end

      // RESP cycle
      @(negedge clk);
      req = v.hold; scramble();
      b_valid = 1'b0; r_valid = 1'b0;
      #1;
      check("gnt_in_resp", gnt, 0);
      check("rsp_valid", rsp_valid, 1);
      check("rsp_valid32", rsp_valid32, 1);
      check("ready_in_resp", {b_ready, r_ready}, 0);
      if (exp_q.size() == 0) begin
         fail_bound("scoreboard_empty");
      end else begin
         exp = exp_q.pop_front();
         check("rsp_rdata", rsp_rdata, exp[31:0]);
         check("rsp_err", rsp_err, exp[32]);
      end
      check("rsp_rdata32", rsp_rdata32, v.wr ? 32'd0 : v.rdata[31:0]);
      check("rsp_err32", rsp_err32, v.exp_err);
      last_rdata = v.exp_rdata;
      last_err   = v.exp_err;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      vec_t abort_v;
      //          wr    be    addr          wdata          rdata                  resp   aw w b ar r  hold  strb   wdata                  rdata         err
      vecs[0] = '{1'b0, 4'hF, 32'h0000_1004, 32'h0,         64'hAAAA_BBBB_1111_2222, 2'b00, 0, 0, 0, 0, 0, 1'b0, 8'h00, 64'h0,                 32'hAAAA_BBBB, 1'b0};
      vecs[1] = '{1'b1, 4'h3, 32'h0000_1000, 32'h1234_5678, 64'h0,                  2'b00, 0, 0, 0, 0, 0, 1'b0, 8'h03, 64'h1234_5678_1234_5678, 32'h0,        1'b0};
      vecs[2] = '{1'b1, 4'hF, 32'h0000_2008, 32'hDEAD_BEEF, 64'h0,                  2'b00, 4, 0, 0, 0, 0, 1'b0, 8'h0F, 64'hDEAD_BEEF_DEAD_BEEF, 32'h0,        1'b0};
      vecs[3] = '{1'b0, 4'hF, 32'h0000_3000, 32'h0,         64'h0123_4567_89AB_CDEF, 2'b10, 0, 0, 0, 0, 0, 1'b1, 8'h00, 64'h0,                 32'h89AB_CDEF, 1'b1};
      vecs[4] = '{1'b1, 4'h8, 32'h0000_100C, 32'hCAFE_F00D, 64'h0,                  2'b11, 1, 3, 2, 0, 0, 1'b0, 8'h80, 64'hCAFE_F00D_CAFE_F00D, 32'h0,        1'b1};
      vecs[5] = '{1'b0, 4'hF, 32'h0000_0006, 32'h0,         64'h5555_6666_7777_8888, 2'b00, 0, 0, 0, 2, 3, 1'b0, 8'h00, 64'h0,                 32'h5555_6666, 1'b0};
      vecs[6] = '{1'b1, 4'hF, 32'h0000_1004, 32'hA5A5_5A5A, 64'h0,                  2'b00, 0, 0, 0, 0, 0, 1'b0, 8'hF0, 64'hA5A5_5A5A_A5A5_5A5A, 32'h0,        1'b0};
      abort_v = '{1'b1, 4'hF, 32'h0000_1000, 32'h0BAD_F00D, 64'h0,                  2'b00, 0, 0, 5, 0, 0, 1'b0, 8'h0F, 64'h0BAD_F00D_0BAD_F00D, 32'h0,        1'b0};

      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("in_reset");
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check_reset_outputs("after_reset");

      for (int i = 0; i < 7; i++) run_txn(vecs[i], 1'b0);

      run_txn(abort_v, 1'b1);
      run_txn(vecs[1], 1'b0);

      for (int i = 0; i < 40; i++) run_txn(make_random(), 1'b0);

      @(negedge clk);
      req = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("final_idle", {rsp_valid, aw_valid, w_valid, ar_valid, b_ready, r_ready}, 0);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
